// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE sequencer for the accumulator datapath.
// Optional single-step PAUSE state enabled by defining CONTROL_SINGLE_STEP_EN.
module control_unit (
    input  logic       clock,
    input  logic       control_reset_n,
    input  logic       start,
    input  logic       step,
    input  logic [4:0] opcode_in,
    input  logic       status_Z,
    input  logic       status_N,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic       pc_src,
    output logic       acc_wr,
    output logic [1:0] acc_src,
    output logic [2:0] alu_op,
    output logic       operand_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       status_wr,
    output logic       halted,
    output logic       illegal_op,
    output logic [2:0] state_out
);

    // state   | meaning
    // IDLE    | waiting for start
    // FETCH   | load IR, advance PC
    // DECODE  | issue data-memory read for memory operands
    // EXECUTE | perform opcode action
    // HALT    | stopped until reset
    // PAUSE   | single-step wait for step
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        HALT    = 3'd4,
        PAUSE   = 3'd5
    } state_t;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_BGT  = 5'b01010;
    localparam logic [4:0] OP_BGE  = 5'b01011;
    localparam logic [4:0] OP_BLT  = 5'b01100;
    localparam logic [4:0] OP_BLE  = 5'b01101;
    localparam logic [4:0] OP_JMP  = 5'b01110;
    localparam logic [4:0] OP_AND  = 5'b01111;
    localparam logic [4:0] OP_OR   = 5'b10000;
    localparam logic [4:0] OP_XOR  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    state_t state_q, state_d;

`ifdef CONTROL_SINGLE_STEP_EN
    localparam state_t AFTER_EXEC = PAUSE;
`else
    localparam state_t AFTER_EXEC = FETCH;
    logic unused_step;
    assign unused_step = step;
`endif

    always_ff @(posedge clock or negedge control_reset_n) begin
        if (!control_reset_n) state_q <= IDLE;
        else                  state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = DECODE;
            DECODE:  state_d = EXECUTE;
            EXECUTE: state_d = (opcode_in == OP_HLT) ? HALT : AFTER_EXEC;
            HALT:    state_d = HALT;
`ifdef CONTROL_SINGLE_STEP_EN
            PAUSE:   if (step) state_d = FETCH;
`else
            PAUSE:   state_d = FETCH;
`endif
            default: state_d = IDLE;
        endcase
    end

    logic branch_taken;
    always_comb begin
        branch_taken = 1'b0;
        case (opcode_in)
            OP_BEQ:  branch_taken = status_Z;
            OP_BNE:  branch_taken = !status_Z;
            OP_BGT:  branch_taken = !status_Z && !status_N;
            OP_BGE:  branch_taken = !status_N;
            OP_BLT:  branch_taken = status_N;
            OP_BLE:  branch_taken = status_N || status_Z;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        ir_wr       = 1'b0;
        pc_wr       = 1'b0;
        pc_src      = 1'b0;
        acc_wr      = 1'b0;
        acc_src     = 2'b00;
        alu_op      = 3'b000;
        operand_sel = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        status_wr   = 1'b0;
        halted      = 1'b0;
        illegal_op  = 1'b0;
        state_out   = state_q;
        case (state_q)
            FETCH: begin
                ir_wr = 1'b1;
                pc_wr = 1'b1;
            end
            DECODE: begin
                case (opcode_in)
                    OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: mem_rd = 1'b1;
                    default: mem_rd = 1'b0;
                endcase
            end
            EXECUTE: begin
                case (opcode_in)
                    OP_HLT: ;
                    OP_STO: mem_wr = 1'b1;
                    OP_LD:  acc_src = 2'b01;
                    OP_LDI: acc_src = 2'b10;
                    OP_ADD, OP_ADDI: alu_op = 3'b000;
                    OP_SUB, OP_SUBI: alu_op = 3'b001;
                    OP_AND: alu_op = 3'b010;
                    OP_OR:  alu_op = 3'b011;
                    OP_XOR: alu_op = 3'b100;
                    OP_NOT: alu_op = 3'b101;
                    OP_JMP: begin
                        pc_wr  = 1'b1;
                        pc_src = 1'b1;
                    end
                    OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE: begin
                        pc_wr  = branch_taken;
                        pc_src = branch_taken;
                    end
                    default: illegal_op = 1'b1;
                endcase
                case (opcode_in)
                    OP_ADDI, OP_SUBI: operand_sel = 1'b1;
                    default:          operand_sel = 1'b0;
                endcase
                case (opcode_in)
                    OP_LD, OP_LDI, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI,
                    OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                        acc_wr    = 1'b1;
                        status_wr = 1'b1;
                    end
                    default: ;
                endcase
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes hand-computed output
// vectors, a monitor pops and compares them at each sample point.
module tb_control_unit;

    logic       clock = 1'b0;
    logic       control_reset_n;
    logic       start, step;
    logic [4:0] opcode_in;
    logic       status_Z, status_N;
    logic       ir_wr, pc_wr, pc_src, acc_wr;
    logic [1:0] acc_src;
    logic [2:0] alu_op;
    logic       operand_sel, mem_rd, mem_wr, status_wr, halted, illegal_op;
    logic [2:0] state_out;

    control_unit dut (
        .clock(clock), .control_reset_n(control_reset_n), .start(start), .step(step),
        .opcode_in(opcode_in), .status_Z(status_Z), .status_N(status_N),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .acc_wr(acc_wr),
        .acc_src(acc_src), .alu_op(alu_op), .operand_sel(operand_sel),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .status_wr(status_wr),
        .halted(halted), .illegal_op(illegal_op), .state_out(state_out)
    );

    always #5 clock = ~clock;

    // Vector layout: ir pc pcsrc acc accsrc[2] alu[3] opsel mrd mwr stw hlt ill state[3]
    localparam logic [17:0] B_IR  = 18'h20000, B_PC  = 18'h10000, B_PCS = 18'h08000;
    localparam logic [17:0] B_ACC = 18'h04000, SRC_MEM = 18'h01000, SRC_IMM = 18'h02000;
    localparam logic [17:0] ALU_SUB = 18'h00200, ALU_AND = 18'h00400, ALU_OR = 18'h00600;
    localparam logic [17:0] ALU_XOR = 18'h00800, ALU_NOT = 18'h00A00;
    localparam logic [17:0] B_OPS = 18'h00100, B_MRD = 18'h00080, B_MWR = 18'h00040;
    localparam logic [17:0] B_STW = 18'h00020, B_HLT = 18'h00010, B_ILL = 18'h00008;
    localparam logic [17:0] S_IDLE = 18'd0, S_FETCH = 18'd1, S_DEC = 18'd2;
    localparam logic [17:0] S_EXE = 18'd3, S_HALT = 18'd4, S_PAUSE = 18'd5;

    typedef struct {
        string       name;
        logic [17:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int checks = 0;
    int failures = 0;
    event sample_ev;

    wire [17:0] got = {ir_wr, pc_wr, pc_src, acc_wr, acc_src, alu_op, operand_sel,
                       mem_rd, mem_wr, status_wr, halted, illegal_op, state_out};

    initial begin : monitor
        sb_item_t it;
        forever begin
            @(negedge clock or sample_ev);
            if (sb.size() > 0) begin
                it = sb.pop_front();
                checks++;
                if (got !== it.exp) begin
                    failures++;
                    $display("FAIL %s: got=%05h expected=%05h", it.name, got, it.exp);
                end
            end
        end
    end

    task automatic push(input string name, input logic [17:0] exp);
        sb_item_t it;
        it.name = name;
        it.exp  = exp;
        sb.push_back(it);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called one cycle into FETCH; leaves the DUT in the cycle after EXECUTE.
    task automatic run_instr(input string name, input logic [4:0] op,
                             input logic [17:0] dec_exp, input logic [17:0] exe_exp);
        opcode_in = op;
        push({name, "_fetch"}, B_IR | B_PC | S_FETCH);
        tick();
        push({name, "_decode"}, dec_exp | S_DEC);
        tick();
        push({name, "_execute"}, exe_exp | S_EXE);
        tick();
`ifdef CONTROL_SINGLE_STEP_EN
        if (op != 5'b00000) begin
            push({name, "_pause"}, S_PAUSE);
            step = 1'b1;
            tick();
            step = 1'b0;
        end
`endif
    endtask

    initial begin : stim
        int wait_cyc;
        control_reset_n = 1'b0;
        start = 1'b0; step = 1'b0; opcode_in = 5'b0;
        status_Z = 1'b0; status_N = 1'b0;
        #1;
        push("reset_async", S_IDLE);
        -> sample_ev;
        tick(); tick();
        control_reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push("idle_no_start", S_IDLE);
            tick();
        end
        start = 1'b1;
        push("idle_start_seen", S_IDLE);
        tick();
        start = 1'b0;

        run_instr("addi", 5'b00101, 18'd0, B_ACC | B_STW | B_OPS);
        run_instr("ld",   5'b00010, B_MRD, B_ACC | B_STW | SRC_MEM);
        run_instr("sub",  5'b00110, B_MRD, B_ACC | B_STW | ALU_SUB);
        run_instr("subi", 5'b00111, 18'd0, B_ACC | B_STW | ALU_SUB | B_OPS);
        run_instr("and",  5'b01111, B_MRD, B_ACC | B_STW | ALU_AND);
        run_instr("or",   5'b10000, B_MRD, B_ACC | B_STW | ALU_OR);
        run_instr("xor",  5'b10001, B_MRD, B_ACC | B_STW | ALU_XOR);
        run_instr("not",  5'b10010, 18'd0, B_ACC | B_STW | ALU_NOT);
        run_instr("sto",  5'b00001, 18'd0, B_MWR);
        run_instr("jmp",  5'b01110, 18'd0, B_PC | B_PCS);
        status_Z = 1'b1; status_N = 1'b0;
        run_instr("beq_taken", 5'b01000, 18'd0, B_PC | B_PCS);
        run_instr("ble_z_taken", 5'b01101, 18'd0, B_PC | B_PCS);
        run_instr("bne_not_taken", 5'b01001, 18'd0, 18'd0);
        status_Z = 1'b0; status_N = 1'b0;
        run_instr("blt_not_taken", 5'b01100, 18'd0, 18'd0);
        run_instr("bgt_taken", 5'b01010, 18'd0, B_PC | B_PCS);
        status_N = 1'b1;
        run_instr("bge_not_taken", 5'b01011, 18'd0, 18'd0);
        run_instr("ble_n_taken", 5'b01101, 18'd0, B_PC | B_PCS);
        run_instr("illegal_1f", 5'b11111, 18'd0, B_ILL);
        run_instr("illegal_13", 5'b10011, 18'd0, B_ILL);
        run_instr("hlt", 5'b00000, 18'd0, 18'd0);

        for (int i = 0; i < 4; i++) begin
            start = i[0];
            push("halt_ignores_start", B_HLT | S_HALT);
            tick();
        end
        start = 1'b0;
        control_reset_n = 1'b0;
        #1;
        push("halt_reset_idle", S_IDLE);
        -> sample_ev;
        tick();
        control_reset_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;

`ifdef CONTROL_SINGLE_STEP_EN
        opcode_in = 5'b00001;
        push("ss_sto_fetch", B_IR | B_PC | S_FETCH);
        tick();
        push("ss_sto_decode", S_DEC);
        tick();
        push("ss_sto_execute", B_MWR | S_EXE);
        tick();
        for (int i = 0; i < 4; i++) begin
            push("ss_pause_hold", S_PAUSE);
            tick();
        end
        step = 1'b1;
        push("ss_pause_step", S_PAUSE);
        tick();
        step = 1'b0;
`else
        step = 1'b1;
`endif
        // Reset asserted while LD is in DECODE must drop mem_rd before the next edge.
        opcode_in = 5'b00010;
        push("ld2_fetch", B_IR | B_PC | S_FETCH);
        tick();
        step = 1'b0;
        push("ld2_decode_mem_rd", B_MRD | S_DEC);
        @(negedge clock);
        #1;
        control_reset_n = 1'b0;
        #1;
        push("reset_mid_decode", S_IDLE);
        -> sample_ev;
        tick();
        push("reset_held_idle", S_IDLE);
        tick();
        control_reset_n = 1'b1;

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(posedge clock);
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
